ara_eoc_monitor: RTL and testbench
==================================

ARA_EOC_MONITOR -- requirements
Module: ara_eoc_monitor

Interface
REQ-001 SHALL have parameter NrChannels, default 1: number of independent exit (tohost) channels, range 1..32.
REQ-002 SHALL have parameter ExitWidth, default 64: width of each exit word; bit 0 = exit valid, bits [ExitWidth-1:1] = exit code.
REQ-003 SHALL have parameter TimeoutCycles, default 0: RUN cycles before timeout; 0 disables timeout; 32-bit.
REQ-004 SHALL have parameter EarlyAbort, default 0: 1 = first non-zero exit code ends the run immediately.
REQ-005 SHALL have one clock and an asynchronous active-low reset, named clk_i and rst_ni.
REQ-006 clk_i  input  1  clock; all state updates on its rising edge.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 start_i  input  1  single-cycle pulse, IDLE -> RUN.
REQ-009 clear_i  input  1  single-cycle pulse, DONE/TIMEOUT -> IDLE.
REQ-010 exit_i  input  NrChannels x ExitWidth  per-channel exit words.
REQ-011 exited_mask_o  output  NrChannels  sticky per-channel "exit seen" flags.
REQ-012 done_o  output  1  run ended (pass, fail or timeout).
REQ-013 pass_o  output  1  valid when done_o; 1 = every channel exited with code 0.
REQ-014 timeout_o  output  1  run ended by timeout.
REQ-015 fail_code_o  output  ExitWidth-1  code of reported failing channel, else 0.
REQ-016 fail_channel_o  output  max(1,$clog2(NrChannels))  index of reported failing channel, else 0.
REQ-017 cycle_count_o  output  64  RUN cycles elapsed, frozen after the run ends.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE, TIMEOUT; reset state IDLE.
REQ-019 IDLE: exit_i ignored, counter held at 0; start_i -> RUN on next edge.
REQ-020 RUN: each edge with exit_i[c][0]=1 and exited_mask_o[c]=0 SHALL set mask bit c and latch code exit_i[c][ExitWidth-1:1]; later changes on channel c are ignored.
REQ-021 RUN: cycle_count_o SHALL increment by 1 per edge, saturating at 2^64-1.
REQ-022 RUN -> DONE when every mask bit is set after the update; done_o high from the following cycle (1-cycle latency from the last exit sample).
REQ-023 EarlyAbort=1: RUN -> DONE on the edge a non-zero code is latched, even with channels outstanding.
REQ-024 pass_o SHALL be 1 in DONE only if all latched codes are 0 and no early abort happened.
REQ-025 Failing channel reported SHALL be the lowest-indexed channel with a non-zero code among those latched by the terminating edge.
REQ-026 TimeoutCycles>0: RUN -> TIMEOUT when cycle_count_o reaches TimeoutCycles with mask incomplete; done_o=1, timeout_o=1, pass_o=0.
REQ-027 Simultaneous completing exit and timeout on one edge SHALL resolve to DONE (exit wins).
REQ-028 start_i outside IDLE and clear_i outside DONE/TIMEOUT SHALL be ignored.
REQ-029 clear_i in DONE/TIMEOUT SHALL zero mask, codes, counter and all status outputs on the same edge as the transition to IDLE.
REQ-030 fail_code_o/fail_channel_o SHALL be 0 except in DONE with pass_o=0.

Reset
REQ-031 rst_ni low SHALL force, asynchronously and regardless of state (including mid-RUN): state IDLE, all outputs 0, latched codes 0.
REQ-032 First edge after rst_ni deassertion SHALL behave as IDLE.

Structure
REQ-033 Shared package ara_eoc_pkg SHALL hold the FSM state enum and a localparam for the 64-bit counter width.
REQ-034 Per-channel capture (valid flag + code register) SHALL be one sub-module, ara_eoc_channel, instantiated NrChannels times.
REQ-035 Block SHALL be synthesizable; no $finish/$display inside; the testbench maps done_o/pass_o to end-of-simulation.

Verification
REQ-036 NrChannels=1: start, exit_i=64'h1 at RUN cycle 10 -> done_o=1 next cycle, pass_o=1, cycle_count_o=11.
REQ-037 NrChannels=4: exits on ch0..3 at cycles 3,7,5,9, ch2 code 5 -> done_o after cycle 9, pass_o=0, fail_channel_o=2, fail_code_o=5.
REQ-038 NrChannels=4, EarlyAbort=1: ch1 exits code 3 at cycle 4, rest silent -> done_o next cycle, fail_channel_o=1, mask=4'b0010.
REQ-039 TimeoutCycles=100, no exits -> timeout_o=done_o=1, pass_o=0, cycle_count_o=100; clear_i -> all outputs 0, IDLE.
REQ-040 TimeoutCycles=20, last exit on the timeout edge -> DONE, timeout_o=0; separately, rst_ni pulse mid-RUN -> outputs 0 immediately.

Source files
------------

// File: rtl/ara_eoc_pkg.sv
// Shared types and constants for the end-of-computation monitor.
package ara_eoc_pkg;

  // Width of the RUN cycle counter
  localparam int unsigned CountWidth = 64;

  // Run-control FSM states
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StDone    = 2'd2,
    StTimeout = 2'd3
  } eoc_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v);
    return (&v) ? v : v + CountWidth'(1);
  endfunction

endpackage

// File: rtl/ara_eoc_channel.sv
// One exit channel: captures the first valid exit word during a run and
// holds its code until the monitor is cleared.
module ara_eoc_channel #(
  parameter int unsigned ExitWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [ExitWidth-1:0] exit_i,
  output logic                 capture_c_o,
  output logic                 valid_o,
  output logic [ExitWidth-2:0] code_o
);

  logic                 valid_q, valid_d;
  logic [ExitWidth-2:0] code_q, code_d;

  // Only the first valid word of a run is taken; later ones are ignored
  assign capture_c_o = en_i & exit_i[0] & ~valid_q;

  // Next-state for the sticky flag and code register
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    if (clr_i) begin
      valid_d = 1'b0;
      code_d  = '0;
    end else if (capture_c_o) begin
      valid_d = 1'b1;
      code_d  = exit_i[ExitWidth-1:1];
    end
  end

  // Capture registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign valid_o = valid_q;
  assign code_o  = code_q;

endmodule

// File: rtl/ara_eoc_monitor.sv
// End-of-computation monitor: watches per-channel exit (tohost) words
// during a run and reports pass/fail/timeout plus the run length.
module ara_eoc_monitor
  import ara_eoc_pkg::*;
#(
  parameter int unsigned NrChannels    = 1,
  parameter int unsigned ExitWidth     = 64,
  parameter logic [31:0] TimeoutCycles = 32'd0,
  parameter bit          EarlyAbort    = 1'b0,
  localparam int unsigned ChanWidth    = (NrChannels > 1) ? $clog2(NrChannels) : 1,
  localparam int unsigned CodeWidth    = ExitWidth - 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic                                 clear_i,
  input  logic [NrChannels-1:0][ExitWidth-1:0] exit_i,
  output logic [NrChannels-1:0]                exited_mask_o,
  output logic                                 done_o,
  output logic                                 pass_o,
  output logic                                 timeout_o,
  output logic [CodeWidth-1:0]                 fail_code_o,
  output logic [ChanWidth-1:0]                 fail_channel_o,
  output logic [CountWidth-1:0]                cycle_count_o
);

  eoc_state_e            state_q, state_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [CodeWidth-1:0]  fail_code_q, fail_code_d;
  logic [ChanWidth-1:0]  fail_chan_q, fail_chan_d;

  logic                                 run_c;
  logic                                 clr_c;
  logic [NrChannels-1:0]                capture_c;
  logic [NrChannels-1:0]                mask_q;
  logic [NrChannels-1:0][CodeWidth-1:0] code_q;
  logic [NrChannels-1:0]                mask_post_c;
  logic [NrChannels-1:0][CodeWidth-1:0] code_post_c;
  logic                                 nz_new_c;
  logic                                 nz_any_c;
  logic [ChanWidth-1:0]                 first_chan_c;
  logic [CodeWidth-1:0]                 first_code_c;

  for (genvar c = 0; c < NrChannels; c++) begin : g_chan
    ara_eoc_channel #(
      .ExitWidth (ExitWidth)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (run_c),
      .clr_i       (clr_c),
      .exit_i      (exit_i[c]),
      .capture_c_o (capture_c[c]),
      .valid_o     (mask_q[c]),
      .code_o      (code_q[c])
    );
  end

  // View of mask and codes as they will be after the current edge
  always_comb begin
    mask_post_c = mask_q | capture_c;
    code_post_c = code_q;
    for (int i = 0; i < int'(NrChannels); i++) begin
      if (capture_c[i]) code_post_c[i] = exit_i[i][ExitWidth-1:1];
    end
  end

  // Lowest-indexed failing channel; scanning downwards lets the lowest win
  always_comb begin
    nz_new_c     = 1'b0;
    nz_any_c     = 1'b0;
    first_chan_c = '0;
    first_code_c = '0;
    for (int i = int'(NrChannels) - 1; i >= 0; i--) begin
      if (mask_post_c[i] && (code_post_c[i] != '0)) begin
        nz_any_c     = 1'b1;
        first_chan_c = ChanWidth'(i);
        first_code_c = code_post_c[i];
        if (capture_c[i]) nz_new_c = 1'b1;
      end
    end
  end

  // Run-control FSM: next state, counter and status
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_code_d = fail_code_q;
    fail_chan_d = fail_chan_q;
    run_c       = 1'b0;
    clr_c       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) state_d = StRun;
      end
      StRun: begin
        run_c   = 1'b1;
        count_d = sat_inc(count_q);
        // Completion is checked first so an exit on the timeout edge wins
        if ((&mask_post_c) || (EarlyAbort && nz_new_c)) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = ~nz_any_c;
          if (nz_any_c) begin
            fail_code_d = first_code_c;
            fail_chan_d = first_chan_c;
          end
        end else if ((TimeoutCycles != 32'd0) &&
                     (count_d == CountWidth'(TimeoutCycles))) begin
          state_d   = StTimeout;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      StDone, StTimeout: begin
        if (clear_i) begin
          state_d     = StIdle;
          clr_c       = 1'b1;
          count_d     = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          fail_code_d = '0;
          fail_chan_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      count_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      fail_chan_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_code_q <= fail_code_d;
      fail_chan_q <= fail_chan_d;
    end
  end

  assign exited_mask_o  = mask_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign timeout_o      = timeout_q;
  assign fail_code_o    = fail_code_q;
  assign fail_channel_o = fail_chan_q;
  assign cycle_count_o  = count_q;

endmodule

// File: tb/tb_ara_eoc_monitor.sv
// Directed bench for ara_eoc_monitor: three configurations driven from one
// vector table, plus a hand-written asynchronous reset sequence.
module tb_ara_eoc_monitor;

  logic clk;
  logic rst_n;

  logic             start_a, clear_a, start_b, clear_b, start_c, clear_c;
  logic [3:0][63:0] exit_a, exit_b;
  logic [0:0][63:0] exit_c;

  logic [3:0]  mask_a, mask_b;
  logic [0:0]  mask_c;
  logic        done_a, pass_a, to_a, done_b, pass_b, to_b, done_c, pass_c, to_c;
  logic [62:0] code_a, code_b, code_c;
  logic [1:0]  ch_a, ch_b;
  logic [0:0]  ch_c;
  logic [63:0] cnt_a, cnt_b, cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  // A: 4 channels, timeout 20, no early abort
  ara_eoc_monitor #(.NrChannels(4), .ExitWidth(64), .TimeoutCycles(32'd20), .EarlyAbort(1'b0)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .clear_i(clear_a), .exit_i(exit_a),
    .exited_mask_o(mask_a), .done_o(done_a), .pass_o(pass_a), .timeout_o(to_a),
    .fail_code_o(code_a), .fail_channel_o(ch_a), .cycle_count_o(cnt_a));

  // B: 4 channels, timeout 100, early abort
  ara_eoc_monitor #(.NrChannels(4), .ExitWidth(64), .TimeoutCycles(32'd100), .EarlyAbort(1'b1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .clear_i(clear_b), .exit_i(exit_b),
    .exited_mask_o(mask_b), .done_o(done_b), .pass_o(pass_b), .timeout_o(to_b),
    .fail_code_o(code_b), .fail_channel_o(ch_b), .cycle_count_o(cnt_b));

  // C: default single channel, no timeout
  ara_eoc_monitor #(.NrChannels(1), .ExitWidth(64), .TimeoutCycles(32'd0), .EarlyAbort(1'b0)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .clear_i(clear_c), .exit_i(exit_c),
    .exited_mask_o(mask_c), .done_o(done_c), .pass_o(pass_c), .timeout_o(to_c),
    .fail_code_o(code_c), .fail_channel_o(ch_c), .cycle_count_o(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    int          gap;
    logic        start;
    logic        clear;
    logic [3:0]  vld;
    logic [3:0][7:0] code;
    logic [3:0]  e_mask;
    logic        e_done;
    logic        e_pass;
    logic        e_to;
    logic [1:0]  e_ch;
    logic [7:0]  e_code;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int d, input int gap, input logic st, input logic cl,
                              input logic [3:0] vld, input logic [31:0] codes,
                              input logic [3:0] em, input logic ed, input logic ep, input logic et,
                              input logic [1:0] ech, input logic [7:0] ecode, input logic [63:0] ecnt);
    vec_t v;
    v.dut = d; v.gap = gap; v.start = st; v.clear = cl; v.vld = vld; v.code = codes;
    v.e_mask = em; v.e_done = ed; v.e_pass = ep; v.e_to = et;
    v.e_ch = ech; v.e_code = ecode; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
    end
  endtask

  task automatic quiet();
    start_a = 1'b0; clear_a = 1'b0; exit_a = '0;
    start_b = 1'b0; clear_b = 1'b0; exit_b = '0;
    start_c = 1'b0; clear_c = 1'b0; exit_c = '0;
  endtask

  task automatic drive(input vec_t v);
    quiet();
    case (v.dut)
      0: begin
        start_a = v.start; clear_a = v.clear;
        for (int c = 0; c < 4; c++) exit_a[c] = {55'd0, v.code[c], v.vld[c]};
      end
      1: begin
        start_b = v.start; clear_b = v.clear;
        for (int c = 0; c < 4; c++) exit_b[c] = {55'd0, v.code[c], v.vld[c]};
      end
      default: begin
        start_c = v.start; clear_c = v.clear;
        exit_c[0] = {55'd0, v.code[0], v.vld[0]};
      end
    endcase
  endtask

  task automatic check_row(input int row, input vec_t v);
    logic [63:0] m, dn, ps, to, ch, cd, cn;
    case (v.dut)
      0: begin m = 64'(mask_a); dn = 64'(done_a); ps = 64'(pass_a); to = 64'(to_a);
               ch = 64'(ch_a); cd = 64'(code_a); cn = cnt_a; end
      1: begin m = 64'(mask_b); dn = 64'(done_b); ps = 64'(pass_b); to = 64'(to_b);
               ch = 64'(ch_b); cd = 64'(code_b); cn = cnt_b; end
      default: begin m = 64'(mask_c); dn = 64'(done_c); ps = 64'(pass_c); to = 64'(to_c);
               ch = 64'(ch_c); cd = 64'(code_c); cn = cnt_c; end
    endcase
    chk("mask",      row, m,  64'(v.e_mask));
    chk("done",      row, dn, 64'(v.e_done));
    chk("pass",      row, ps, 64'(v.e_pass));
    chk("timeout",   row, to, 64'(v.e_to));
    chk("fail_chan", row, ch, 64'(v.e_ch));
    chk("fail_code", row, cd, 64'(v.e_code));
    chk("count",     row, cn, v.e_cnt);
  endtask

  // Quiet edges first, then one edge with the row's inputs, then compare
  task automatic apply(input int row, input vec_t v);
    for (int k = 0; k < v.gap; k++) begin
      @(negedge clk); quiet();
      @(posedge clk);
    end
    @(negedge clk); drive(v);
    @(posedge clk); #1;
    check_row(row, v);
  endtask

  initial begin
    //            d gap st cl vld      codes         mask    dn ps to ch  code  cnt
    // A: four channels finishing at counts 3,7,5,9 with ch2 failing
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    tbl.push_back(mk(0, 0, 1, 0, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    tbl.push_back(mk(0, 3, 0, 0, 4'b0001, 32'h00000000, 4'b0001, 0, 0, 0, 0, 8'h0, 64'd4));
    tbl.push_back(mk(0, 1, 0, 1, 4'b0100, 32'h00050000, 4'b0101, 0, 0, 0, 0, 8'h0, 64'd6));
    tbl.push_back(mk(0, 1, 1, 0, 4'b0011, 32'h00000007, 4'b0111, 0, 0, 0, 0, 8'h0, 64'd8));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1000, 32'h00000000, 4'b1111, 1, 0, 0, 2, 8'h5, 64'd10));
    tbl.push_back(mk(0, 2, 1, 0, 4'b0000, 32'h00000000, 4'b1111, 1, 0, 0, 2, 8'h5, 64'd10));
    tbl.push_back(mk(0, 0, 0, 1, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b1111, 32'h01020304, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    // A: last exit lands on the timeout edge -> clean pass
    tbl.push_back(mk(0, 0, 1, 0, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    tbl.push_back(mk(0, 2, 0, 0, 4'b0111, 32'h00000000, 4'b0111, 0, 0, 0, 0, 8'h0, 64'd3));
    tbl.push_back(mk(0, 15, 0, 0, 4'b0000, 32'h00000000, 4'b0111, 0, 0, 0, 0, 8'h0, 64'd19));
    tbl.push_back(mk(0, 0, 0, 0, 4'b1000, 32'h00000000, 4'b1111, 1, 1, 0, 0, 8'h0, 64'd20));
    tbl.push_back(mk(0, 0, 0, 1, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    // A: nonzero code without early abort keeps running, then times out
    tbl.push_back(mk(0, 0, 1, 0, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 32'h00000002, 4'b0001, 0, 0, 0, 0, 8'h0, 64'd1));
    tbl.push_back(mk(0, 18, 0, 0, 4'b0000, 32'h00000000, 4'b0001, 1, 0, 1, 0, 8'h0, 64'd20));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0010, 32'h00000000, 4'b0001, 1, 0, 1, 0, 8'h0, 64'd20));
    tbl.push_back(mk(0, 0, 0, 1, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    // B: early abort on ch1 code 3
    tbl.push_back(mk(1, 0, 1, 0, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    tbl.push_back(mk(1, 4, 0, 0, 4'b0010, 32'h00000300, 4'b0010, 1, 0, 0, 1, 8'h3, 64'd5));
    tbl.push_back(mk(1, 0, 0, 1, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    // B: zero code does not abort; two failures on one edge report the lower
    tbl.push_back(mk(1, 0, 1, 0, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    tbl.push_back(mk(1, 1, 0, 0, 4'b0001, 32'h00000000, 4'b0001, 0, 0, 0, 0, 8'h0, 64'd2));
    tbl.push_back(mk(1, 0, 0, 0, 4'b1100, 32'h09040000, 4'b1101, 1, 0, 0, 2, 8'h4, 64'd3));
    tbl.push_back(mk(1, 0, 0, 1, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    // B: timeout at 100 with no exits, then clear
    tbl.push_back(mk(1, 0, 1, 0, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    tbl.push_back(mk(1, 98, 0, 0, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd99));
    tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 1, 0, 8'h0, 64'd100));
    tbl.push_back(mk(1, 0, 0, 1, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    // C: single channel exits cleanly when the count reads 10
    tbl.push_back(mk(2, 0, 1, 0, 4'b0000, 32'h00000000, 4'b0000, 0, 0, 0, 0, 8'h0, 64'd0));
    tbl.push_back(mk(2, 10, 0, 0, 4'b0001, 32'h00000000, 4'b0001, 1, 1, 0, 0, 8'h0, 64'd11));

    quiet();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done_a", -1, 64'(done_a), 64'd0);
    chk("rst_cnt_b",  -1, cnt_b, 64'd0);
    chk("rst_mask_c", -1, 64'(mask_c), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) apply(r, tbl[r]);

    // Asynchronous reset in the middle of a run on A
    @(negedge clk); quiet(); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); quiet(); exit_a[0] = {55'd0, 8'h06, 1'b1};
    @(posedge clk);
    @(negedge clk); quiet();
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_cnt_a",  100, cnt_a, 64'd3);
    chk("pre_rst_mask_a", 100, 64'(mask_a), 64'd1);
    chk("pre_rst_done_c", 100, 64'(done_c), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_cnt_a",  101, cnt_a, 64'd0);
    chk("rst_mask_a", 101, 64'(mask_a), 64'd0);
    chk("rst_done_c", 101, 64'(done_c), 64'd0);
    chk("rst_pass_c", 101, 64'(pass_c), 64'd0);
    chk("rst_cnt_c",  101, cnt_c, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cnt_a",  102, cnt_a, 64'd0);
    chk("post_rst_done_a", 102, 64'(done_a), 64'd0);
    @(negedge clk); quiet();
    @(posedge clk); #1;
    chk("post_rst_run_a", 103, cnt_a, 64'd1);
    @(negedge clk); quiet();
    for (int c = 0; c < 4; c++) exit_a[c] = 64'h1;
    @(posedge clk); #1;
    chk("post_rst_done_a2", 104, 64'(done_a), 64'd1);
    chk("post_rst_pass_a",  104, 64'(pass_a), 64'd1);
    chk("post_rst_cnt_a2",  104, cnt_a, 64'd2);
    @(negedge clk); quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
